reciprocal_scheduler: RTL

//  Shares one reciprocal interpolation datapath (f(x)=NUMERATOR/x, 16.16 fixed point) among
//  NB_REQ requesters, e.g. triangle setup 1/w, 1/z and texture LOD.

---
 rtl/reciprocal_scheduler_pkg.sv | 29 ++
 rtl/reciprocal_scheduler_reciprocal.sv | 57 +++++
 rtl/reciprocal_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/reciprocal_scheduler_pkg.sv
// Shared fixed-point types and the round-robin pick helper for the reciprocal scheduler.
package reciprocal_scheduler_pkg;

    typedef logic [31:0] fx32_t;

    localparam fx32_t FX_ONE  = 32'h0001_0000;
    localparam int    MAX_REQ = 8;
    localparam int    PTR_W   = 3;

    // First set bit of req at or after ptr, wrapping modulo nb; 0 when req is empty.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 nb);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] j;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = PTR_W'((int'(ptr) + i) % nb);
            if (i < nb && !found && req[j]) begin
                pick  = j;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reciprocal_scheduler_reciprocal.sv
// Combinational NUMERATOR/x in 16.16: piecewise-linear interpolation between knots evenly
// spaced over [0, END_INTERPOLATION_REGION); knots carry the exact truncated quotient.
module reciprocal
    import reciprocal_scheduler_pkg::*;
#(
    parameter logic [31:0] NUMERATOR                = 32'h100,
    parameter int          END_INTERPOLATION_REGION = 4096,
    parameter int          NB_SUBDIVISIONS          = 2048
) (
    input  logic [31:0] x_i,
    output logic [31:0] z_o
);

    localparam logic [63:0] REGION_FX = 64'(END_INTERPOLATION_REGION) << 16;
    localparam int          SEG_SHIFT = $clog2(REGION_FX / 64'(NB_SUBDIVISIONS));
    localparam int          IDX_W     = $clog2(NB_SUBDIVISIONS);

    // Knot 0 (x = 0) is clamped to NUMERATOR itself rather than infinity.
    function automatic fx32_t knot(input int i);
        if (i == 0) return fx32_t'(NUMERATOR * FX_ONE);
        return fx32_t'((64'(NUMERATOR) << 32) / (64'(i) << SEG_SHIFT));
    endfunction

    fx32_t lut [NB_SUBDIVISIONS+1];

    for (genvar g = 0; g <= NB_SUBDIVISIONS; g++) begin : g_lut
        assign lut[g] = knot(g);
    end

    logic [IDX_W:0]     idx_lo;
    logic [IDX_W:0]     idx_hi;
    logic [SEG_SHIFT-1:0] frac;
    logic               out_of_range;
    fx32_t              lo;
    fx32_t              hi;
    fx32_t              diff;
    logic [63:0]        prod;
    logic [63:0]        corr;
    logic               unused_corr;

    assign idx_lo       = {1'b0, x_i[SEG_SHIFT +: IDX_W]};
    assign idx_hi       = idx_lo + 1'b1;
    assign frac         = x_i[SEG_SHIFT-1:0];
    assign out_of_range = x_i[31] || (64'(x_i) >= REGION_FX);
    assign unused_corr  = ^corr[63:32];

    always_comb begin
        lo   = lut[idx_lo];
        hi   = lut[idx_hi];
        diff = lo - hi;
        prod = {32'b0, diff} * {{(64-SEG_SHIFT){1'b0}}, frac};
        corr = prod >> SEG_SHIFT;
        if (out_of_range) z_o = '0;
        else              z_o = lo - corr[31:0];
    end

endmodule

// File: rtl/reciprocal_scheduler.sv
// Round-robin scheduler sharing one reciprocal datapath among NB_REQ requesters through a
// two-stage registered pipeline; each result is returned to the requester that issued it.
module reciprocal_scheduler
    import reciprocal_scheduler_pkg::*;
#(
    parameter int          NB_REQ                   = 4,
    parameter logic [31:0] NUMERATOR                = 32'h100,
    parameter int          END_INTERPOLATION_REGION = 4096,
    parameter int          NB_SUBDIVISIONS          = 2048
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [NB_REQ-1:0]    req_valid_i,
    input  logic [NB_REQ*32-1:0] req_x_i,
    output logic [NB_REQ-1:0]    req_ready_o,
    output logic [NB_REQ-1:0]    rsp_valid_o,
    output logic [31:0]          rsp_z_o,
    input  logic [NB_REQ-1:0]    rsp_ready_i,
    output logic                 busy_o
);

    localparam int ID_W = $clog2(NB_REQ);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A requester holds valid and its operand until accepted; ready may depend on valid
    // and on rsp_ready_i, and never on the accepting requester's own rsp_ready_i alone.

    logic             v1, v2;
    fx32_t            x1, z2, z_next;
    logic [ID_W-1:0]  id1, id2, rr_ptr, grant_id, next_ptr;
    logic             adv1, adv2, grant;
    logic [MAX_REQ-1:0] req_pad;

    assign adv2     = !v2 || rsp_ready_i[id2];
    assign adv1     = !v1 || adv2;
    assign grant    = !reset_i && adv1 && (|req_valid_i);
    assign next_ptr = (grant_id == ID_W'(NB_REQ-1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_pad                = '0;
        req_pad[NB_REQ-1:0]    = req_valid_i;
        grant_id               = ID_W'(rr_pick(req_pad, PTR_W'(rr_ptr), NB_REQ));
        req_ready_o            = '0;
        if (grant) req_ready_o = NB_REQ'(1) << grant_id;
        rsp_valid_o            = '0;
        if (v2) rsp_valid_o    = NB_REQ'(1) << id2;
    end

    assign rsp_z_o = z2;
    assign busy_o  = v1 || v2;

    reciprocal #(
        .NUMERATOR                (NUMERATOR),
        .END_INTERPOLATION_REGION (END_INTERPOLATION_REGION),
        .NB_SUBDIVISIONS          (NB_SUBDIVISIONS)
    ) u_reciprocal (
        .x_i (x1),
        .z_o (z_next)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            x1     <= '0;
            id1    <= '0;
            z2     <= '0;
            id2    <= '0;
            rr_ptr <= '0;
        end else begin
            if (adv1) begin
                if (grant) begin
                    x1     <= req_x_i[32*grant_id +: 32];
                    id1    <= grant_id;
                    v1     <= 1'b1;
                    rr_ptr <= next_ptr;
                end else begin
                    v1 <= 1'b0;
                end
            end
            // z2 only reloads with live work so the bus keeps its last result when idle.
            if (adv2) begin
                v2  <= v1;
                id2 <= id1;
                if (v1) z2 <= z_next;
            end
        end
    end

endmodule
